layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_seq_if.sv | 23 ++
 rtl/layer_sequencer.sv | 113 +++++++++++
 tb/tb_layer_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/layer_seq_if.sv
// Handshake bundle between the layer sequencer, the weight store and the compute datapath.
// The master side drives the control inputs; the sequencer sits on the slave side.
interface layer_seq_if;
   logic       start;
   logic       abort;
   logic       w_valid;
   logic       layer_done;
   logic [2:0] cs;
   logic       compute_start;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      output start, abort, w_valid, layer_done,
      input  cs, compute_start, busy, done, error
   );

   modport slave (
      input  start, abort, w_valid, layer_done,
      output cs, compute_start, busy, done, error
   );
endinterface

// File: rtl/layer_sequencer.sv
// Steps a network pass through LAYER0..AFFINE. Each layer loads its weights, then runs.
// A guard window masks stale w_valid after every cs change, and a load timeout aborts the pass.
module layer_sequencer #(
   parameter int GUARD   = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   layer_seq_if.slave  bus
);
   typedef enum logic [2:0] {
      CS_IDLE   = 3'd0,
      CS_LAYER0 = 3'd1,
      CS_LAYER1 = 3'd2,
      CS_LAYER2 = 3'd3,
      CS_LAYER3 = 3'd4,
      CS_AFFINE = 3'd5,
      CS_FINISH = 3'd6
   } cs_t;

   typedef enum logic {PH_LOAD = 1'b0, PH_RUN = 1'b1} phase_t;

   localparam int          GW         = $clog2(GUARD + 2);
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD);
   localparam logic [10:0] TMO_LAST   = 11'(TIMEOUT - 1);

   cs_t           cs_reg;
   phase_t        phase_reg;
   logic [GW-1:0] guard_reg;
   logic [10:0]   tmo_reg;
   logic          compute_start_reg;
   logic          done_reg;
   logic          busy_reg;
   logic          error_reg;
   logic          guard_ok;

   assign guard_ok = (guard_reg >= GUARD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_reg            <= CS_IDLE;
         phase_reg         <= PH_LOAD;
         guard_reg         <= '0;
         tmo_reg           <= '0;
         compute_start_reg <= 1'b0;
         done_reg          <= 1'b0;
         busy_reg          <= 1'b0;
         error_reg         <= 1'b0;
      end else begin
         compute_start_reg <= 1'b0;
         done_reg          <= 1'b0;
         if (bus.abort) begin
            cs_reg    <= CS_IDLE;
            phase_reg <= PH_LOAD;
            guard_reg <= '0;
            tmo_reg   <= '0;
            busy_reg  <= 1'b0;
         end else begin
            case (cs_reg)
               CS_IDLE: begin
                  if (bus.start) begin
                     cs_reg    <= CS_LAYER0;
                     phase_reg <= PH_LOAD;
                     guard_reg <= '0;
                     tmo_reg   <= '0;
                     busy_reg  <= 1'b1;
                     error_reg <= 1'b0;
                  end
               end
               CS_LAYER0, CS_LAYER1, CS_LAYER2, CS_LAYER3, CS_AFFINE: begin
                  if (phase_reg == PH_LOAD) begin
                     // A qualifying w_valid wins over a timeout landing on the same edge.
                     if (guard_ok && bus.w_valid) begin
                        compute_start_reg <= 1'b1;
                        phase_reg         <= PH_RUN;
                     end else if (tmo_reg == TMO_LAST) begin
                        error_reg <= 1'b1;
                        cs_reg    <= CS_IDLE;
                        busy_reg  <= 1'b0;
                        guard_reg <= '0;
                        tmo_reg   <= '0;
                     end else begin
                        if (!guard_ok) guard_reg <= guard_reg + 1'b1;
                        if (tmo_reg != 11'h7FF) tmo_reg <= tmo_reg + 11'd1;
                     end
                  end else if (bus.layer_done) begin
                     phase_reg <= PH_LOAD;
                     guard_reg <= '0;
                     tmo_reg   <= '0;
                     if (cs_reg == CS_AFFINE) begin
                        cs_reg   <= CS_FINISH;
                        done_reg <= 1'b1;
                     end else begin
                        cs_reg <= cs_t'(cs_reg + 3'd1);
                     end
                  end
               end
               default: begin
                  cs_reg    <= CS_IDLE;
                  phase_reg <= PH_LOAD;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.cs            = cs_reg;
   assign bus.compute_start = compute_start_reg;
   assign bus.done          = done_reg;
   assign bus.busy          = busy_reg;
   assign bus.error         = error_reg;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed-plus-random bench for layer_sequencer; expectations come from the timing rules
// (guard window, timeout length, state order) expressed as plain arithmetic.
module tb_layer_sequencer;
   localparam int GUARD   = 3;
   localparam int TIMEOUT = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   layer_seq_if bus ();

   layer_sequencer #(.GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks   = 0;
   int n_pass     = 0;
   int cstart_cnt = 0;
   int done_cnt   = 0;

   always @(negedge clk) begin
      cstart_cnt <= cstart_cnt + int'(bus.compute_start);
      done_cnt   <= done_cnt + int'(bus.done);
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic start_pass();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("start_cs", bus.cs, 1);
      chk("start_busy", bus.busy, 1);
      chk("start_error", bus.error, 0);
   endtask

   // Called at the first sample after cs became L; w_valid rises d cycles after the change.
   task automatic run_layer(input int L, input int d, input int ld_wait, input bit ld_in_load,
                            input bit wv_in_run, input bit stale, input bit start_noise,
                            input bit abort_on_done);
      int k_acc;
      int base;
      int dbase;
      k_acc = ((d > GUARD) ? d : GUARD) + 1;
      base  = cstart_cnt;
      dbase = done_cnt;
      chk($sformatf("L%0d_entry_cs", L), bus.cs, L);
      chk($sformatf("L%0d_entry_busy", L), bus.busy, 1);
      if (start_noise) bus.start = 1'b1;
      for (int k = 0; k <= k_acc + 1; k++) begin
         if (k > 0) step();
         if (stale && k == 1) bus.w_valid = 1'b0;
         if (k == d) bus.w_valid = 1'b1;
         if (ld_in_load) bus.layer_done = (k == 0);
         if (k == k_acc - 1) chk($sformatf("L%0d_no_early_cstart", L), cstart_cnt - base, 0);
         if (k == k_acc) begin
            chk($sformatf("L%0d_cstart", L), bus.compute_start, 1);
            bus.w_valid = wv_in_run;
         end
         if (k == k_acc + 1) begin
            chk($sformatf("L%0d_cstart_width", L), bus.compute_start, 0);
            chk($sformatf("L%0d_run_cs", L), bus.cs, L);
         end
      end
      repeat (ld_wait) step();
      bus.layer_done = 1'b1;
      bus.abort      = abort_on_done;
      step();
      bus.layer_done = 1'b0;
      bus.abort      = 1'b0;
      bus.start      = 1'b0;
      if (abort_on_done) begin
         chk("abort_cs", bus.cs, 0);
         chk("abort_busy", bus.busy, 0);
         chk("abort_done", bus.done, 0);
         repeat (3) step();
         chk("abort_stays_idle", bus.cs, 0);
         chk("abort_no_done", done_cnt - dbase, 0);
      end else if (L == 5) begin
         chk("finish_cs", bus.cs, 6);
         chk("finish_done", bus.done, 1);
         step();
         chk("idle_cs", bus.cs, 0);
         chk("idle_done", bus.done, 0);
         chk("idle_busy", bus.busy, 0);
      end else begin
         chk($sformatf("L%0d_advance_cs", L), bus.cs, L + 1);
      end
   endtask

   initial begin
      int cs_base;
      int dn_base;
      int d;
      bit stale;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.w_valid    = 1'b0;
      bus.layer_done = 1'b0;

      repeat (3) step();
      chk("rst_cs", bus.cs, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cstart", bus.compute_start, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      rst_n = 1'b1;
      step();

      // Nominal pass with slow weight loads.
      cs_base = cstart_cnt;
      dn_base = done_cnt;
      start_pass();
      for (int L = 1; L <= 5; L++) run_layer(L, 290, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("nominal_cstart_count", cstart_cnt - cs_base, 5);
      chk("nominal_done_count", done_cnt - dn_base, 1);
      chk("nominal_error", bus.error, 0);

      // Randomized passes: stale valid, ignored start/layer_done, concurrent done+valid.
      for (int p = 0; p < 4; p++) begin
         cs_base = cstart_cnt;
         dn_base = done_cnt;
         start_pass();
         for (int L = 1; L <= 5; L++) begin
            stale = bus.w_valid;
            d = stale ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 7));
            run_layer(L, d, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                      (L == 1) ? 1'b1 : 1'($urandom_range(0, 1)), stale, (L == 2), 1'b0);
         end
         bus.w_valid = 1'b0;
         step();
         chk("rand_cstart_count", cstart_cnt - cs_base, 5);
         chk("rand_done_count", done_cnt - dn_base, 1);
         chk("rand_end_cs", bus.cs, 0);
      end

      // Load timeout with w_valid never arriving.
      start_pass();
      for (int k = 1; k <= TIMEOUT; k++) begin
         step();
         if (k == TIMEOUT - 1) begin
            chk("tmo_before_cs", bus.cs, 1);
            chk("tmo_before_error", bus.error, 0);
         end
         if (k == TIMEOUT) begin
            chk("tmo_cs", bus.cs, 0);
            chk("tmo_error", bus.error, 1);
            chk("tmo_busy", bus.busy, 0);
         end
      end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      repeat (2) step();
      chk("error_sticky", bus.error, 1);
      start_pass();

      // Abort in LAYER2 RUN coinciding with layer_done.
      dn_base = done_cnt;
      run_layer(1, int'($urandom_range(0, 6)), 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_layer(2, int'($urandom_range(0, 6)), 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_layer(3, int'($urandom_range(0, 6)), 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("abort_error_unchanged", bus.error, 0);

      // Asynchronous reset mid AFFINE LOAD.
      start_pass();
      for (int L = 1; L <= 4; L++)
         run_layer(L, int'($urandom_range(0, 6)), 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_cs", bus.cs, 5);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cs", bus.cs, 0);
      chk("async_rst_busy", bus.busy, 0);
      cs_base = cstart_cnt;
      dn_base = done_cnt;
      bus.w_valid = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.layer_done = 1'(i % 2);
         step();
      end
      bus.layer_done = 1'b0;
      bus.w_valid    = 1'b0;
      step();
      chk("post_rst_cs", bus.cs, 0);
      chk("post_rst_cstart", cstart_cnt - cs_base, 0);
      chk("post_rst_done", done_cnt - dn_base, 0);
      chk("post_rst_error", bus.error, 0);

      // Guard boundary sweep around GUARD.
      cs_base = cstart_cnt;
      start_pass();
      run_layer(1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_layer(2, GUARD - 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_layer(3, GUARD, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_layer(4, GUARD + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_layer(5, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sweep_cstart_count", cstart_cnt - cs_base, 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
